ps2_kb_receiver: RTL and testbench

Parametrised PS/2 keyboard receiver running entirely in the system clock domain. It oversamples and filters `KB_Clk`/`KB_Data`, frames and checks each 11-bit PS/2 frame, and decodes `E0`/`F0` prefixes into make/break key events. Events are buffered in a FIFO behind a valid/ready port. It replaces the edge-clocked keyboard input and sits between the board PS/2 pins and the processor's I/O register file.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_event_fifo.sv | 46 ++++
 rtl/ps2_kb_receiver.sv | 198 +++++++++++++++++++
 tb/tb_ps2_kb_receiver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  typedef logic [1:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE   = 2'd0;
  localparam ps2_state_t ST_DATA   = 2'd1;
  localparam ps2_state_t ST_PARITY = 2'd2;
  localparam ps2_state_t ST_STOP   = 2'd3;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO of decoded key events; head is presented combinationally.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  ps2_event_t din,
  input  logic       pop,
  output ps2_event_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  ps2_event_t    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_wr = push && (!full || do_rd);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_kb_receiver.sv
// PS/2 keyboard receiver: pin conditioning, frame FSM, E0/F0 decoder, event FIFO.
// Optional parity checking is enabled with `define PS2_PARITY_CHECK_EN.
module ps2_kb_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       KB_Clk,
  input  logic       KB_Data,
  output logic       Event_Valid,
  input  logic       Event_Ready,
  output logic [7:0] Event_Code,
  output logic       Event_Break,
  output logic       Event_Ext,
  output logic [7:0] KB_Char,
  output logic       Parity_Err,
  output logic       Frame_Err,
  output logic       Overflow
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic           kc_s1, kc_s2, kd_s1, kd_s2;
  logic           filt;
  logic [FCW-1:0] fcnt;
  logic           fall;

  ps2_state_t     state;
  logic [2:0]     bit_cnt;
  logic [7:0]     sr;
  logic [TW-1:0]  to_cnt;
  logic           byte_valid;
  logic           frame_err;

  logic           ext_pend, brk_pend;
  logic           evt_push;
  ps2_event_t     evt_in;
  ps2_event_t     evt_head;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [7:0]     kb_char;
  logic           overflow;

  // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_s1 <= 1'b1;
      kc_s2 <= 1'b1;
      kd_s1 <= 1'b1;
      kd_s2 <= 1'b1;
      filt  <= 1'b1;
      fcnt  <= '0;
      fall  <= 1'b0;
    end else begin
      kc_s1 <= KB_Clk;
      kc_s2 <= kc_s1;
      kd_s1 <= KB_Data;
      kd_s2 <= kd_s1;
      fall  <= 1'b0;
      if (kc_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FC_LAST) begin
        filt <= kc_s2;
        fcnt <= '0;
        fall <= filt;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  logic parity_err;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      sr         <= '0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
      if (state == ST_IDLE || fall) to_cnt <= '0;
      else                          to_cnt <= to_cnt + TW'(1);

      if (state != ST_IDLE && !fall && to_cnt == TO_LAST) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            bit_cnt <= '0;
            if (!kd_s2) state     <= ST_DATA;
            else        frame_err <= 1'b1;
          end
          ST_DATA: begin
            sr      <= {kd_s2, sr[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= kd_s2;
`endif
            state <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (!kd_s2) frame_err <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
            else if (!(^{par_bit, sr})) parity_err <= 1'b1;
`endif
            else byte_valid <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign Parity_Err = parity_err;
`else
  assign Parity_Err = 1'b0;
`endif

  // Prefix flags survive frame errors so a retransmitted byte still decodes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      evt_push <= 1'b0;
      evt_in   <= '0;
      kb_char  <= PS2_BREAK_PREFIX;
    end else begin
      evt_push <= 1'b0;
      if (byte_valid) begin
        if (sr == PS2_EXT_PREFIX) begin
          ext_pend <= 1'b1;
        end else if (sr == PS2_BREAK_PREFIX) begin
          brk_pend <= 1'b1;
        end else begin
          evt_push <= 1'b1;
          evt_in   <= '{ext: ext_pend, brk: brk_pend, code: sr};
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
          if (brk_pend) kb_char <= sr;
        end
      end
    end
  end

  assign fifo_pop = Event_Valid && Event_Ready;

  ps2_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .reset (Reset),
    .push  (evt_push),
    .din   (evt_in),
    .pop   (fifo_pop),
    .dout  (evt_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge Clk) begin
    if (Reset)                                   overflow <= 1'b0;
    else if (evt_push && fifo_full && !fifo_pop) overflow <= 1'b1;
  end

  assign Event_Valid = !fifo_empty;
  assign Event_Code  = evt_head.code;
  assign Event_Break = evt_head.brk;
  assign Event_Ext   = evt_head.ext;
  assign KB_Char     = kb_char;
  assign Frame_Err   = frame_err;
  assign Overflow    = overflow;

endmodule

// File: tb/tb_ps2_kb_receiver.sv
// Directed self-checking bench for ps2_kb_receiver.
module tb_ps2_kb_receiver;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       KB_Clk;
  logic       KB_Data;
  logic       Event_Valid;
  logic       Event_Ready;
  logic [7:0] Event_Code;
  logic       Event_Break;
  logic       Event_Ext;
  logic [7:0] KB_Char;
  logic       Parity_Err;
  logic       Frame_Err;
  logic       Overflow;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  logic [9:0] got_q[$];

  ps2_kb_receiver #(
    .FIFO_DEPTH     (4),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (300)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .KB_Clk      (KB_Clk),
    .KB_Data     (KB_Data),
    .Event_Valid (Event_Valid),
    .Event_Ready (Event_Ready),
    .Event_Code  (Event_Code),
    .Event_Break (Event_Break),
    .Event_Ext   (Event_Ext),
    .KB_Char     (KB_Char),
    .Parity_Err  (Parity_Err),
    .Frame_Err   (Frame_Err),
    .Overflow    (Overflow)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Frame_Err)  fe_cnt++;
    if (Parity_Err) pe_cnt++;
    if (Event_Valid && Event_Ready) got_q.push_back({Event_Ext, Event_Break, Event_Code});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic [9:0] exp);
    logic [9:0] e;
    if (got_q.size() == 0) begin
      chk(tag, 32'hFFFF_FFFF, {22'd0, exp});
    end else begin
      e = got_q.pop_front();
      chk(tag, {22'd0, e}, {22'd0, exp});
    end
  endtask

  // One PS/2 bit: data set up, clock low for 10 cycles, high for 10.
  task automatic send_bit(input logic b);
    KB_Data = b;
    repeat (5) @(negedge Clk);
    KB_Clk = 1'b0;
    repeat (10) @(negedge Clk);
    KB_Clk = 1'b1;
    repeat (5) @(negedge Clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f = mk_frame(b, bad_par);
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    repeat (10) @(negedge Clk);
  endtask

  initial begin
    logic [10:0] f;
    int fe0, pe0;

    Reset = 1'b1; KB_Clk = 1'b1; KB_Data = 1'b1; Event_Ready = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_valid",  {31'd0, Event_Valid}, 0);
    chk("rst_code",   {24'd0, Event_Code},  0);
    chk("rst_brk",    {31'd0, Event_Break}, 0);
    chk("rst_ext",    {31'd0, Event_Ext},   0);
    chk("rst_char",   {24'd0, KB_Char},     32'hF0);
    chk("rst_perr",   {31'd0, Parity_Err},  0);
    chk("rst_ferr",   {31'd0, Frame_Err},   0);
    chk("rst_ovf",    {31'd0, Overflow},    0);

    // Single make code with latency check around the stop-bit edge.
    f = mk_frame(8'h1C, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    KB_Data = 1'b1;
    repeat (5) @(negedge Clk);
    KB_Clk = 1'b0;
    repeat (8) @(posedge Clk);
    #1 chk("lat_valid_early", {31'd0, Event_Valid}, 0);
    @(posedge Clk);
    #1 chk("lat_valid_on", {31'd0, Event_Valid}, 1);
    repeat (9) @(negedge Clk);
    KB_Clk = 1'b1;
    repeat (15) @(negedge Clk);
    chk("make_cnt", got_q.size(), 1);
    chk_evt("make_1c", 10'h01C);

    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk_evt("brk_1c", 10'h11C);
    chk("brk_char", {24'd0, KB_Char}, 32'h1C);

    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk_evt("extbrk_75", 10'h375);
    chk("extbrk_char", {24'd0, KB_Char}, 32'h75);
    chk("clean_ferr", fe_cnt, 0);

    pe0 = pe_cnt;
    send_frame(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_pulse", pe_cnt - pe0, 1);
    chk("par_noevt", got_q.size(), 0);
`else
    chk("par_pulse", pe_cnt - pe0, 0);
    chk_evt("par_ignored", 10'h01C);
`endif

    // Abandon a frame after the start bit and 4 data bits.
    fe0 = fe_cnt;
    f = mk_frame(8'h55, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(f[i]);
    repeat (350) @(negedge Clk);
    chk("to_pulse", fe_cnt - fe0, 1);
    chk("to_noevt", got_q.size(), 0);
    send_frame(8'h32, 1'b0);
    chk_evt("to_next_32", 10'h032);

    Event_Ready = 1'b0;
    send_frame(8'h1C, 1'b0);
    send_frame(8'h32, 1'b0);
    send_frame(8'h21, 1'b0);
    send_frame(8'h23, 1'b0);
    chk("ovf_clear4", {31'd0, Overflow}, 0);
    send_frame(8'h2B, 1'b0);
    chk("ovf_set",  {31'd0, Overflow},   1);
    chk("ovf_head", {24'd0, Event_Code}, 32'h1C);
    Event_Ready = 1'b1;
    repeat (10) @(negedge Clk);
    chk("ovf_cnt", got_q.size(), 4);
    chk_evt("ovf_e0", 10'h01C);
    chk_evt("ovf_e1", 10'h032);
    chk_evt("ovf_e2", 10'h021);
    chk_evt("ovf_e3", 10'h023);

    // Reset in the middle of a frame.
    f = mk_frame(8'hAA, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(f[i]);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("mrst_char",  {24'd0, KB_Char},     32'hF0);
    chk("mrst_valid", {31'd0, Event_Valid}, 0);
    chk("mrst_ovf",   {31'd0, Overflow},    0);
    send_frame(8'h1C, 1'b0);
    chk("mrst_cnt", got_q.size(), 1);
    chk_evt("mrst_1c", 10'h01C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
